sort_stream_fifo: RTL and testbench

//  Stream channel between sort cells; the responder end of the ap_fifo handshake the cells drive.

---
 rtl/sort_stream_fifo.sv | 89 ++++++++
 tb/tb_sort_stream_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sort_stream_fifo.sv
// Show-ahead stream FIFO linking adjacent sort cells (ap_fifo responder side).
// Registered full/empty flags, occupancy count and sticky overflow/underflow flags.
module sort_stream_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   usedw,
    output logic                  ovf_err,
    output logic                  udf_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_acc, rd_acc;

    assign wr_acc = if_write & full_n_q;
    assign rd_acc = if_read & empty_n_q;

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q | (if_write & ~full_n_q);
        udf_d     = udf_q | (if_read & ~empty_n_q);
        if (wr_acc)
            wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
        if (rd_acc)
            rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + 1'b1;
        // Simultaneous accepted read and write leave occupancy unchanged.
        if (wr_acc && !rd_acc)
            cnt_d = cnt_q + 1'b1;
        else if (rd_acc && !wr_acc)
            cnt_d = cnt_q - 1'b1;
        empty_n_d = (cnt_d != '0);
        full_n_d  = (cnt_d != FULL_CNT);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            full_n_q  <= full_n_d;
            empty_n_q <= empty_n_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    // Storage is never cleared; stale contents are hidden by if_empty_n.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst && wr_acc)
            mem_q[wptr_q] <= if_din;
    end

    assign if_dout    = mem_q[rptr_q];
    assign if_full_n  = full_n_q;
    assign if_empty_n = empty_n_q;
    assign usedw      = cnt_q;
    assign ovf_err    = ovf_q;
    assign udf_err    = udf_q;

endmodule

// File: tb/tb_sort_stream_fifo.sv
// Drives a DEPTH=2 and a DEPTH=3 FIFO with identical traffic and checks
// both against per-depth queue models, plus directed scenario checks.
module tb_sort_stream_fifo;
    typedef logic [31:0] word_t;

    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b0;
    word_t       if_din = '0;
    logic        if_write = 1'b0;
    logic        if_read = 1'b0;

    logic        if_full_n2, if_empty_n2, ovf_err2, udf_err2;
    word_t       if_dout2;
    logic [1:0]  usedw2;
    logic        if_full_n3, if_empty_n3, ovf_err3, udf_err3;
    word_t       if_dout3;
    logic [2:0]  usedw3;

    sort_stream_fifo #(.DATA_WIDTH(32), .DEPTH(2), .ADDR_WIDTH(1)) u_dut2 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .if_din(if_din), .if_write(if_write),
        .if_full_n(if_full_n2), .if_dout(if_dout2), .if_read(if_read),
        .if_empty_n(if_empty_n2), .usedw(usedw2), .ovf_err(ovf_err2), .udf_err(udf_err2)
    );

    sort_stream_fifo #(.DATA_WIDTH(32), .DEPTH(3), .ADDR_WIDTH(2)) u_dut3 (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .if_din(if_din), .if_write(if_write),
        .if_full_n(if_full_n3), .if_dout(if_dout3), .if_read(if_read),
        .if_empty_n(if_empty_n3), .usedw(usedw3), .ovf_err(ovf_err3), .udf_err(udf_err3)
    );

    always #5 ap_clk = ~ap_clk;

    int    errs = 0;
    int    checks = 0;
    word_t mq [2][$];
    int    dep [2] = '{2, 3};
    bit    movf [2];
    bit    mudf [2];
    bit    cap_en = 1'b0;
    word_t outs [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_dut(input int k, input word_t dout, input logic [2:0] used,
                             input logic fn, input logic en, input logic ov, input logic ud);
        string p;
        p = $sformatf("d%0d", dep[k]);
        chk({p, " usedw"},   64'(used), 64'(mq[k].size()));
        chk({p, " full_n"},  64'(fn),   64'(mq[k].size() != dep[k]));
        chk({p, " empty_n"}, 64'(en),   64'(mq[k].size() != 0));
        chk({p, " ovf"},     64'(ov),   64'(movf[k]));
        chk({p, " udf"},     64'(ud),   64'(mudf[k]));
        if (mq[k].size() != 0)
            chk({p, " dout"}, 64'(dout), 64'(mq[k][0]));
    endtask

    // One clock: apply inputs, advance the models, then compare both DUTs.
    task automatic cycle(input bit w, input bit r, input word_t d, input bit rst);
        ap_rst   = rst;
        if_write = w;
        if_read  = r;
        if_din   = d;
        if (cap_en && r && !rst && if_empty_n3)
            outs.push_back(if_dout3);
        @(posedge ap_clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mq[k].delete();
                movf[k] = 1'b0;
                mudf[k] = 1'b0;
            end else begin
                bit full, empty;
                full  = (mq[k].size() == dep[k]);
                empty = (mq[k].size() == 0);
                if (w && full)  movf[k] = 1'b1;
                if (r && empty) mudf[k] = 1'b1;
                if (r && !empty) void'(mq[k].pop_front());
                if (w && !full) mq[k].push_back(d);
            end
        end
        #1;
        check_dut(0, if_dout2, {1'b0, usedw2}, if_full_n2, if_empty_n2, ovf_err2, udf_err2);
        check_dut(1, if_dout3, usedw3, if_full_n3, if_empty_n3, ovf_err3, udf_err3);
    endtask

    initial begin
        int nw;
        int budget;

        // Reset state, with requests present that must be ignored.
        cycle(1, 1, 32'h55, 1);
        chk("rst usedw", 64'(usedw2), 0);
        chk("rst full_n", 64'(if_full_n2), 1);
        chk("rst empty_n", 64'(if_empty_n2), 0);

        // Two writes into DEPTH=2, then drain.
        cycle(1, 0, 32'd5, 0);
        chk("t1 empty_n after 1st", 64'(if_empty_n2), 1);
        cycle(1, 0, 32'hFFFFFFFD, 0);
        chk("t1 full_n", 64'(if_full_n2), 0);
        chk("t1 usedw", 64'(usedw2), 2);
        chk("t1 dout", 64'(if_dout2), 5);
        cycle(0, 1, 0, 0);
        chk("t2 dout 2nd", 64'(if_dout2), 64'h FFFFFFFD);
        cycle(0, 1, 0, 0);
        chk("t2 empty_n", 64'(if_empty_n2), 0);
        chk("t2 usedw", 64'(usedw2), 0);
        chk("t2 errs", 64'({ovf_err2, udf_err2}), 0);

        // DEPTH=3 ordering across several pointer wraps.
        cycle(0, 0, 0, 1);
        cap_en = 1'b1;
        nw = 0;
        budget = 0;
        while (outs.size() < 10 && budget < 200) begin
            bit w, r;
            w = (nw < 10) && ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 1) == 1;
            if (w && if_full_n3) begin
                cycle(1, r, word_t'(nw), 0);
                nw++;
            end else begin
                cycle(0, r, 0, 0);
            end
            chk("t3 usedw bound", 64'(usedw3 <= 3'd3), 1);
            budget++;
        end
        cap_en = 1'b0;
        chk("t3 count", 64'(outs.size()), 10);
        for (int i = 0; i < 10 && i < outs.size(); i++)
            chk($sformatf("t3 order[%0d]", i), 64'(outs[i]), 64'(i));

        // Full + write + read: only the read goes through.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 32'd100, 0);
        cycle(1, 0, 32'd101, 0);
        cycle(1, 0, 32'd102, 0);
        chk("t4 ovf before", 64'(ovf_err3), 0);
        cycle(1, 1, 32'd7, 0);
        chk("t4 ovf", 64'(ovf_err3), 1);
        chk("t4 usedw", 64'(usedw3), 2);
        chk("t4 dout", 64'(if_dout3), 101);

        // Empty + write + read: only the write goes through.
        cycle(0, 0, 0, 1);
        cycle(1, 1, 32'd9, 0);
        chk("t5 udf", 64'(udf_err3), 1);
        chk("t5 empty_n", 64'(if_empty_n3), 1);
        chk("t5 dout", 64'(if_dout3), 9);
        chk("t5 usedw", 64'(usedw3), 1);

        // Streaming at occupancy 1, then reset mid-run.
        for (int i = 1; i <= 3; i++) begin
            cycle(1, 1, word_t'(i), 0);
            chk($sformatf("t6 usedw %0d", i), 64'(usedw3), 1);
            chk($sformatf("t6 dout %0d", i), 64'(if_dout3), 64'(i));
        end
        cycle(1, 1, 32'd4, 1);
        chk("t6 rst usedw", 64'(usedw3), 0);
        chk("t6 rst empty_n", 64'(if_empty_n3), 0);
        chk("t6 rst full_n", 64'(if_full_n3), 1);
        chk("t6 rst errs", 64'({ovf_err3, udf_err3}), 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 49) == 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
